fp_regfile_sb: RTL and testbench
================================

// Module: fp_regfile_sb
// PURPOSE
//  FP register file (f0-f31) with scoreboard. Sits directly upstream of the FP execute units
//  (fsgnj/fsgnjn and the arithmetic units): supplies the x1/x2 operands and accepts
//  FP-unit results on a writeback port.
//  Blocks issue on RAW/WAW hazards against in-flight writes and bypasses same-cycle writeback data.
// PARAMETERS
//  NREG      32   number of FP registers; index width = $clog2(NREG)
//  XLEN      32   register data width (single precision)
//  CNT_W     32   width of the stall-cycle performance counter
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst          in   1      asynchronous, active-high reset
//  rs1_addr     in   5      source 1 index
//  rs2_addr     in   5      source 2 index
//  rs1_used     in   1      instruction reads rs1 (enables hazard check)
//  rs2_used     in   1      instruction reads rs2
//  rs1_data     out  32     source 1 operand (-> x1 of execute units)
//  rs2_data     out  32     source 2 operand (-> x2)
//  issue_valid  in   1      decode presents an FP instruction
//  issue_wr     in   1      instruction writes FP rd
//  issue_rd     in   5      destination index
//  issue_ready  out  1      no hazard; issue accepted when issue_valid & issue_ready
//  wb_valid     in   1      execute unit returns a result
//  wb_rd        in   5      result destination index
//  wb_data      in   32     result value
//  flush        in   1      pipeline flush: discard all in-flight writes
//  busy_mask    out  32     current scoreboard bits (debug)
//  stall_cnt    out  CNT_W  cycles with issue_valid & ~issue_ready
// BEHAVIOUR
//  Reset (async, immediate): all regs = 0, busy_mask = 0, stall_cnt = 0;
//   hence rs*_data = 0 and issue_ready = 1 while rst is high.
//  f0 is an ordinary register; it is not hardwired to zero.
//  Read: combinational, 0-cycle latency. If wb_valid & wb_rd == rsN_addr, rsN_data = wb_data
//   (write-through bypass); otherwise rsN_data = regs[rsN_addr].
//  Effective busy: eff = busy_mask & ~(wb_valid ? onehot(wb_rd) : 0)
//   (a same-cycle writeback clears its hazard).
//  issue_ready = ~(rs1_used & eff[rs1_addr]) & ~(rs2_used & eff[rs2_addr])
//   & ~(issue_wr & eff[issue_rd]). issue_ready is 1 when flush = 1.
//  A rd conflict against an in-flight write is a WAW hazard and stalls the issue.
//  issue_ready does not depend on issue_valid (no combinational loop with decode).
//  Fire = issue_valid & issue_ready & issue_wr & ~flush -> busy[issue_rd] set at next edge.
//  Writeback: wb_valid -> regs[wb_rd] <= wb_data and busy[wb_rd] cleared at next edge.
//   The write happens even if the busy bit is already clear, for example after a flush.
//  Simultaneous wb and fire on the same index: the register takes wb_data and busy ends set,
//   because the set wins over the clear.
//  flush: busy_mask <= 0 at next edge and overrides any same-cycle fire.
//   A wb in the flush cycle still updates the register.
//  stall_cnt: +1 each cycle with issue_valid & ~issue_ready. Saturates at all-ones; never wraps.
//  Not reset by flush.
//  Reset mid-operation: all in-flight state is discarded.
//   Writebacks arriving after reset deassertion write the register normally.
//  Register-file update and busy update are a single cycle; there are no multi-cycle states.
// TESTING
//  T1 reset: assert rst mid-run -> rs1_data = rs2_data = 0, busy_mask = 0, stall_cnt = 0,
//   issue_ready = 1.
//  T2 RAW: fire rd=5; next cycle rs1_addr=5, rs1_used=1 -> issue_ready = 0 and stall_cnt
//   increments. wb rd=5 data=32'hBF800000 -> same cycle issue_ready = 1 and
//   rs1_data = 32'hBF800000.
//  T3 WAW and collision: busy[7] set, issue rd=7 -> stall. With wb rd=7 in the same cycle the
//   issue fires; next cycle busy[7] = 1 and reg7 = wb_data.
//  T4 unused source: busy[3] set, rs2_addr=3, rs2_used=0 -> issue_ready = 1.
//  T5 flush: busy_mask = 32'h0000_00F0, flush with a same-cycle fire rd=1 ->
//   next cycle busy_mask = 0. A later wb rd=4 data=32'h40490FDB writes reg4.
//  T6 saturation: force stall_cnt = 32'hFFFF_FFFE, stall 3 cycles -> stall_cnt = 32'hFFFF_FFFF.

Source files
------------

// File: rtl/fp_regfile_sb.sv
// fp_regfile_sb: single-precision FP register file with a write scoreboard.
// Supplies bypassed x1/x2 operands, blocks hazardous issues and counts stall cycles.
module fp_regfile_sb #(
    parameter int NREG  = 32,
    parameter int XLEN  = 32,
    parameter int CNT_W = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    input  logic             rs1_used,
    input  logic             rs2_used,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             issue_valid,
    input  logic             issue_wr,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic [NREG-1:0]  busy_mask,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [XLEN-1:0]  regs [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [CNT_W-1:0] stall_q;

    logic             wb_act;
    logic [NREG-1:0]  wb_onehot;
    logic [NREG-1:0]  fire_onehot;
    logic [NREG-1:0]  eff_busy;
    logic             rs1_hz;
    logic             rs2_hz;
    logic             rd_hz;
    logic             fire;
    logic             stall;

    // Writeback is ignored combinationally while rst is high so operands read as zero.
    assign wb_act = wb_valid & ~rst;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wb_onehot   = '0;
        fire_onehot = '0;
        if (wb_act) wb_onehot[wb_rd] = 1'b1;
        if (fire)   fire_onehot[issue_rd] = 1'b1;
    end

    // A result landing this cycle no longer blocks its readers or a new writer.
    assign eff_busy = busy_q & ~wb_onehot;

    always_comb begin
        rs1_hz      = rs1_used & eff_busy[rs1_addr];
        rs2_hz      = rs2_used & eff_busy[rs2_addr];
        rd_hz       = issue_wr & eff_busy[issue_rd];
        issue_ready = flush | ~(rs1_hz | rs2_hz | rd_hz);
    end

    assign fire  = issue_valid & issue_ready & issue_wr & ~flush;
    assign stall = issue_valid & ~issue_ready;

    // Set wins over a same-index clear; flush wins over everything.
    always_comb begin
        busy_d = (busy_q & ~wb_onehot) | fire_onehot;
        if (flush) busy_d = '0;
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (wb_act && (wb_rd == rs1_addr)) rs1_data = wb_data;
        if (wb_act && (wb_rd == rs2_addr)) rs2_data = wb_data;
    end

    // NOTE: the array is held in flops rather than a RAM so it can take the async clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_valid) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // NOTE: sequential state uses <= so each flop samples pre-edge values of its peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (stall && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign busy_mask = busy_q;
    assign stall_cnt = stall_q;

    a_flush_clears: assert property (@(posedge clk) disable iff (rst)
        flush |=> (busy_q == '0));

    a_cnt_saturates: assert property (@(posedge clk) disable iff (rst)
        (stall_q == '1) |=> (stall_q == '1));

endmodule

// File: tb/tb_fp_regfile_sb.sv
// tb_fp_regfile_sb: directed scenario bench for fp_regfile_sb.
// A second instance with a 2-bit stall counter exercises saturation in a few cycles.
module tb_fp_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_rd;
    logic        rs1_used, rs2_used, issue_valid, issue_wr, wb_valid, flush;
    logic [31:0] wb_data;

    logic [31:0] rs1_data, rs2_data, busy_mask, stall_cnt;
    logic        issue_ready;
    logic [31:0] rs1_data_s, rs2_data_s, busy_mask_s;
    logic [1:0]  stall_cnt_s;
    logic        issue_ready_s;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fp_regfile_sb dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .busy_mask(busy_mask), .stall_cnt(stall_cnt)
    );

    fp_regfile_sb #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rs1_data(rs1_data_s), .rs2_data(rs2_data_s),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .issue_ready(issue_ready_s),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .busy_mask(busy_mask_s), .stall_cnt(stall_cnt_s)
    );

    task automatic idle();
        rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        issue_valid = 1'b0; issue_wr = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
    endtask

    // Inputs change on the falling edge; state is observed after the next one.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fire_rd(input logic [4:0] rd);
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = rd;
        step();
        idle();
    endtask

    task automatic writeback(input logic [4:0] rd, input logic [31:0] data);
        wb_valid = 1'b1; wb_rd = rd; wb_data = data;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #1;
        tests_run++; if (rs1_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rs1: got %h want 00000000", rs1_data); end
        tests_run++; if (rs2_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rs2: got %h want 00000000", rs2_data); end
        tests_run++; if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL reset_busy: got %h want 00000000", busy_mask); end
        tests_run++; if (stall_cnt !== 32'h0) begin tests_failed++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h3F80_0000; rs1_addr = 5'd2;
        #1;
        tests_run++; if (rs1_data !== 32'h3F80_0000) begin tests_failed++; $display("FAIL wr_bypass: got %h want 3f800000", rs1_data); end
        step();
        idle();
        rs1_addr = 5'd2;
        #1;
        tests_run++; if (rs1_data !== 32'h3F80_0000) begin tests_failed++; $display("FAIL wr_stored: got %h want 3f800000", rs1_data); end
        writeback(5'd0, 32'hC000_0000);
        rs2_addr = 5'd0;
        #1;
        tests_run++; if (rs2_data !== 32'hC000_0000) begin tests_failed++; $display("FAIL wr_f0: got %h want c0000000", rs2_data); end
    endtask

    task automatic test_raw();
        idle();
        fire_rd(5'd5);
        #1;
        tests_run++; if (busy_mask !== 32'h0000_0020) begin tests_failed++; $display("FAIL raw_busy_set: got %h want 00000020", busy_mask); end
        issue_valid = 1'b1; rs1_addr = 5'd5; rs1_used = 1'b1;
        #1;
        tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL raw_stall: got %b want 0", issue_ready); end
        step();
        tests_run++; if (stall_cnt !== 32'd1) begin tests_failed++; $display("FAIL raw_stall_cnt: got %0d want 1", stall_cnt); end
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hBF80_0000;
        #1;
        tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL raw_wb_ready: got %b want 1", issue_ready); end
        tests_run++; if (rs1_data !== 32'hBF80_0000) begin tests_failed++; $display("FAIL raw_wb_bypass: got %h want bf800000", rs1_data); end
        step();
        idle();
        #1;
        tests_run++; if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL raw_busy_clr: got %h want 00000000", busy_mask); end
        tests_run++; if (stall_cnt !== 32'd1) begin tests_failed++; $display("FAIL raw_cnt_hold: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_waw_collision();
        fire_rd(5'd7);
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd7;
        #1;
        tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL waw_stall: got %b want 0", issue_ready); end
        step();
        tests_run++; if (stall_cnt !== 32'd2) begin tests_failed++; $display("FAIL waw_stall_cnt: got %0d want 2", stall_cnt); end
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h4040_0000;
        #1;
        tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL waw_wb_ready: got %b want 1", issue_ready); end
        step();
        idle();
        rs1_addr = 5'd7;
        #1;
        tests_run++; if (busy_mask !== 32'h0000_0080) begin tests_failed++; $display("FAIL waw_set_wins: got %h want 00000080", busy_mask); end
        tests_run++; if (rs1_data !== 32'h4040_0000) begin tests_failed++; $display("FAIL waw_reg7: got %h want 40400000", rs1_data); end
        writeback(5'd7, 32'h4100_0000);
        #1;
        tests_run++; if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL waw_clear: got %h want 00000000", busy_mask); end
    endtask

    task automatic test_unused_source();
        fire_rd(5'd3);
        issue_valid = 1'b1; rs2_addr = 5'd3; rs2_used = 1'b0; rs1_addr = 5'd0; rs1_used = 1'b1;
        #1;
        tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL unused_ready: got %b want 1", issue_ready); end
        rs2_used = 1'b1;
        #1;
        tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL used_rs2_stall: got %b want 0", issue_ready); end
        issue_valid = 1'b0;
        #1;
        tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_no_valid: got %b want 0", issue_ready); end
        step();
        tests_run++; if (stall_cnt !== 32'd2) begin tests_failed++; $display("FAIL no_valid_no_count: got %0d want 2", stall_cnt); end
        idle();
        writeback(5'd3, 32'h0);
    endtask

    task automatic test_flush();
        for (int r = 4; r < 8; r++) fire_rd(5'(r));
        #1;
        tests_run++; if (busy_mask !== 32'h0000_00F0) begin tests_failed++; $display("FAIL flush_pre_busy: got %h want 000000f0", busy_mask); end
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd4;
        #1;
        tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_pre_waw: got %b want 0", issue_ready); end
        flush = 1'b1;
        #1;
        tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready: got %b want 1", issue_ready); end
        issue_rd = 5'd1; wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h1234_5678;
        step();
        idle();
        rs1_addr = 5'd6;
        #1;
        tests_run++; if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL flush_busy: got %h want 00000000", busy_mask); end
        tests_run++; if (rs1_data !== 32'h1234_5678) begin tests_failed++; $display("FAIL flush_wb_reg6: got %h want 12345678", rs1_data); end
        writeback(5'd4, 32'h4049_0FDB);
        rs2_addr = 5'd4;
        #1;
        tests_run++; if (rs2_data !== 32'h4049_0FDB) begin tests_failed++; $display("FAIL flush_late_wb: got %h want 40490fdb", rs2_data); end
        tests_run++; if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL flush_late_busy: got %h want 00000000", busy_mask); end
        tests_run++; if (stall_cnt !== 32'd2) begin tests_failed++; $display("FAIL flush_cnt_kept: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_saturation();
        fire_rd(5'd8);
        issue_valid = 1'b1; rs1_addr = 5'd8; rs1_used = 1'b1; rs2_addr = 5'd4;
        #1;
        tests_run++; if (issue_ready_s !== 1'b0) begin tests_failed++; $display("FAIL sat_ready: got %b want 0", issue_ready_s); end
        tests_run++; if (busy_mask_s !== 32'h0000_0100) begin tests_failed++; $display("FAIL sat_busy: got %h want 00000100", busy_mask_s); end
        tests_run++; if (rs1_data_s !== 32'h0) begin tests_failed++; $display("FAIL sat_rs1: got %h want 00000000", rs1_data_s); end
        tests_run++; if (rs2_data_s !== 32'h4049_0FDB) begin tests_failed++; $display("FAIL sat_rs2: got %h want 40490fdb", rs2_data_s); end
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++; if (stall_cnt !== 32'(3 + i)) begin tests_failed++; $display("FAIL sat_main_cnt: got %0d want %0d", stall_cnt, 3 + i); end
            tests_run++; if (stall_cnt_s !== 2'd3) begin tests_failed++; $display("FAIL sat_small_cnt: got %0d want 3", stall_cnt_s); end
        end
        idle();
        writeback(5'd8, 32'h0);
    endtask

    task automatic test_reset_mid();
        fire_rd(5'd12);
        issue_valid = 1'b1; rs2_addr = 5'd12; rs2_used = 1'b1; rs1_addr = 5'd4;
        step();
        tests_run++; if (stall_cnt !== 32'd6) begin tests_failed++; $display("FAIL mid_pre_cnt: got %0d want 6", stall_cnt); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (rs1_data !== 32'h0) begin tests_failed++; $display("FAIL mid_rs1: got %h want 00000000", rs1_data); end
        tests_run++; if (rs2_data !== 32'h0) begin tests_failed++; $display("FAIL mid_rs2: got %h want 00000000", rs2_data); end
        tests_run++; if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL mid_busy: got %h want 00000000", busy_mask); end
        tests_run++; if (stall_cnt !== 32'h0) begin tests_failed++; $display("FAIL mid_cnt: got %0d want 0", stall_cnt); end
        tests_run++; if (stall_cnt_s !== 2'd0) begin tests_failed++; $display("FAIL mid_cnt_small: got %0d want 0", stall_cnt_s); end
        tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_ready: got %b want 1", issue_ready); end
        @(negedge clk);
        rst = 1'b0;
        idle();
        writeback(5'd12, 32'hC049_0FDB);
        rs1_addr = 5'd12; rs2_addr = 5'd4;
        #1;
        tests_run++; if (rs1_data !== 32'hC049_0FDB) begin tests_failed++; $display("FAIL post_rst_wb: got %h want c0490fdb", rs1_data); end
        tests_run++; if (rs2_data !== 32'h0) begin tests_failed++; $display("FAIL post_rst_reg4: got %h want 00000000", rs2_data); end
        tests_run++; if (busy_mask !== 32'h0) begin tests_failed++; $display("FAIL post_rst_busy: got %h want 00000000", busy_mask); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_raw();
        test_waw_collision();
        test_unused_source();
        test_flush();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
